// File: rtl/ysyx_220053_ifu_fetch.sv
// ysyx_220053_ifu_fetch
//
// Instruction fetch unit. It holds the fetch PC and issues one word request
// at a time over a valid/ready instruction-memory port. Returned words go
// into a small circular fetch queue, which is presented to decode over a
// valid/ready handshake. A redirect flushes the queue, reloads the PC and
// squashes any response that is still in flight.
//
// Build option:
//   YSYX_IFU_MISALIGN_TRAP_EN - when defined, a fetch from a PC with
//   pc[1:0] != 0 sends no memory request. A faulting entry {pc, 0, err=1}
//   is queued instead, and fetch halts until the next redirect.
//
// Ports:
//   clk, rst                    - core clock, synchronous active-high reset
//   imem_req_valid/ready/addr   - fetch request channel (addr = current PC)
//   imem_resp_valid/data/err    - single-cycle response pulse, always taken
//   redirect_valid/pc           - flush and restart fetch at redirect_pc
//   out_valid/ready             - decode handshake on the queue head
//   out_pc/inst/err             - contents of the queue head
module ysyx_220053_ifu_fetch #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000,
  parameter int              FQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            imem_resp_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic            out_err
);

  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HALT} state_t;

  state_t            state_reg;
  logic [XLEN-1:0]   pc_reg;
  logic [PTR_W-1:0]  head_reg;
  logic [PTR_W-1:0]  tail_reg;
  logic [CNT_W-1:0]  count_reg;

  logic [XLEN-1:0]   fq_pc_reg   [FQ_DEPTH];
  logic [31:0]       fq_inst_reg [FQ_DEPTH];
  logic              fq_err_reg  [FQ_DEPTH];

  logic              has_space;
  logic              issue_slot;
  logic              misaligned;
  logic              req_fire;
  logic              resp_push;
  logic              trap_push;
  logic              push;
  logic              pop;
  logic              outstanding;
  logic [31:0]       push_inst;
  logic              push_err;

`ifdef YSYX_IFU_MISALIGN_TRAP_EN
  assign misaligned = (pc_reg[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // The queue must have room before a request is issued. That guarantees a
  // push never finds it full.
  assign has_space  = (count_reg < CNT_W'(FQ_DEPTH));
  assign issue_slot = (state_reg == S_REQ) && has_space;

  assign imem_req_valid = !rst && issue_slot && !misaligned;
  assign imem_req_addr  = pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_push = (state_reg == S_WAIT) && imem_resp_valid;
  assign trap_push = issue_slot && misaligned;

  // A redirect flushes the queue, so it overrides both push and pop.
  assign push = !redirect_valid && (resp_push || trap_push);
  assign pop  = !redirect_valid && out_valid && out_ready;

  assign push_inst = trap_push ? 32'h0 : imem_resp_data;
  assign push_err  = trap_push ? 1'b1  : imem_resp_err;

  // A request is still owed a response if it was accepted earlier and no
  // response is arriving now, or if it is being accepted this cycle.
  assign outstanding = (((state_reg == S_WAIT) || (state_reg == S_DROP)) && !imem_resp_valid)
                       || req_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_REQ;
      pc_reg    <= RESET_PC;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (redirect_valid) begin
      pc_reg    <= redirect_pc;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      state_reg <= outstanding ? S_DROP : S_REQ;
    end else begin
      case (state_reg)
        S_REQ: begin
          if (trap_push) begin
            state_reg <= S_HALT;
          end else if (req_fire) begin
            state_reg <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            pc_reg    <= pc_reg + XLEN'(4);
            state_reg <= imem_resp_err ? S_HALT : S_REQ;
          end
        end
        S_DROP: begin
          if (imem_resp_valid) begin
            state_reg <= S_REQ;
          end
        end
        S_HALT: begin
          state_reg <= S_HALT;
        end
        default: state_reg <= S_REQ;
      endcase

      if (push) begin
        tail_reg <= tail_reg + PTR_W'(1);
      end
      if (pop) begin
        head_reg <= head_reg + PTR_W'(1);
      end
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Queue storage. It has no reset because the valid state lives entirely in
  // count_reg.
  generate
    for (genvar gi = 0; gi < FQ_DEPTH; gi++) begin : g_fq
      always_ff @(posedge clk) begin
        if (push && (tail_reg == PTR_W'(gi))) begin
          fq_pc_reg[gi]   <= pc_reg;
          fq_inst_reg[gi] <= push_inst;
          fq_err_reg[gi]  <= push_err;
        end
      end
    end
  endgenerate

  assign out_valid = !rst && (count_reg != '0);
  assign out_pc    = fq_pc_reg[head_reg];
  assign out_inst  = fq_inst_reg[head_reg];
  assign out_err   = fq_err_reg[head_reg];

endmodule

// File: tb/tb_ysyx_220053_ifu_fetch.sv
// Bench for ysyx_220053_ifu_fetch. A behavioural memory answers accepted
// requests after a programmable latency. Every response it expects the DUT
// to keep is pushed to a scoreboard queue. Each decode handshake pops the
// queue and compares the entry.
module tb_ysyx_220053_ifu_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_err;

  ysyx_220053_ifu_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
    .out_err         (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        err;
  } ent_t;

  typedef struct {
    logic        out_rdy;
    logic        mem_rdy;
    logic        exp_req_valid;
    logic [63:0] exp_req_addr;
    logic        exp_out_valid;
    logic [63:0] exp_out_pc;
  } vec_t;

  ent_t sb[$];

  int checks = 0;
  int errors = 0;

  // Memory model state.
  bit          mem_pend;
  bit          mem_squash;
  int          mem_cnt;
  int          lat;
  logic [63:0] mem_addr;
  logic [63:0] err_addr;
  int          n_req;
  logic [63:0] last_acc_addr;
  bit          prev_stall;
  logic [63:0] prev_addr;

  // Snapshot of DUT outputs taken mid-cycle.
  logic        s_req_valid;
  logic [63:0] s_req_addr;
  logic        s_out_valid;
  logic [63:0] s_out_pc;
  logic [31:0] s_out_inst;
  logic        s_out_err;

  function automatic logic [31:0] data_of(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock cycle. Inputs for this cycle are already applied. The task
  // samples and scores at the falling edge, then updates the memory model
  // just after the rising edge.
  task automatic tick();
    ent_t e;
    bit   acc;
    @(negedge clk);
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_out_valid = out_valid;
    s_out_pc    = out_pc;
    s_out_inst  = out_inst;
    s_out_err   = out_err;
    acc = imem_req_valid && imem_req_ready;

    if (!rst && prev_stall) begin
      check("req_hold_valid", {63'd0, imem_req_valid}, 64'd1);
      check("req_hold_addr", imem_req_addr, prev_addr);
    end
    prev_stall = !rst && !redirect_valid && imem_req_valid && !imem_req_ready;
    prev_addr  = imem_req_addr;

    if (rst) begin
      sb.delete();
      mem_pend   = 0;
      mem_squash = 0;
    end else if (redirect_valid) begin
      sb.delete();
      if (mem_pend || acc) mem_squash = 1;
    end else begin
      check("out_valid_track", {63'd0, out_valid}, {63'd0, sb.size() != 0});
      if (out_valid && out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        check("out_pc", out_pc, e.pc);
        check("out_inst", {32'd0, out_inst}, {32'd0, e.inst});
        check("out_err", {63'd0, out_err}, {63'd0, e.err});
        $display("pop pc=%h inst=%h err=%0b", out_pc, out_inst, out_err);
      end
      if (imem_resp_valid && mem_pend && !mem_squash) begin
        e.pc   = mem_addr;
        e.inst = imem_resp_data;
        e.err  = imem_resp_err;
        sb.push_back(e);
      end
    end

    if (!rst && imem_resp_valid) begin
      mem_pend   = 0;
      mem_squash = 0;
    end
    if (!rst && acc) begin
      mem_pend      = 1;
      mem_addr      = imem_req_addr;
      mem_cnt       = lat;
      last_acc_addr = imem_req_addr;
      n_req++;
      if (redirect_valid) mem_squash = 1;
    end

    @(posedge clk);
    #1;
    imem_resp_valid = 1'b0;
    imem_resp_err   = 1'b0;
    if (mem_pend && mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = data_of(mem_addr);
        imem_resp_err   = (mem_addr == err_addr);
      end
    end
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b0;
    tick();
    tick();
    rst   = 1'b0;
    n_req = 0;
  endtask

  task automatic redirect_to(input logic [63:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    tick();
    redirect_valid = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    bit found;

    vecs[0] = '{1'b1, 1'b1, 1'b1, 64'h8000_0000, 1'b0, 64'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 64'h0,         1'b0, 64'h0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 64'h8000_0004, 1'b1, 64'h8000_0000};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 64'h0,         1'b0, 64'h0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 64'h8000_0008, 1'b1, 64'h8000_0004};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 64'h0,         1'b0, 64'h0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 64'h8000_000C, 1'b1, 64'h8000_0008};

    rst             = 1'b1;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    imem_resp_err   = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 64'h0;
    out_ready       = 1'b1;
    lat             = 1;
    err_addr        = '1;
    mem_pend        = 0;
    mem_squash      = 0;
    mem_cnt         = 0;
    mem_addr        = '0;
    n_req           = 0;
    last_acc_addr   = '0;
    prev_stall      = 0;
    prev_addr       = '0;

    // Reset state and zero-wait streaming.
    do_reset();
    check("rst_req_valid", {63'd0, s_req_valid}, 64'd0);
    check("rst_out_valid", {63'd0, s_out_valid}, 64'd0);
    for (int i = 0; i < 7; i++) begin
      out_ready      = vecs[i].out_rdy;
      imem_req_ready = vecs[i].mem_rdy;
      tick();
      check($sformatf("vec%0d_req_valid", i), {63'd0, s_req_valid}, {63'd0, vecs[i].exp_req_valid});
      if (vecs[i].exp_req_valid) check($sformatf("vec%0d_req_addr", i), s_req_addr, vecs[i].exp_req_addr);
      check($sformatf("vec%0d_out_valid", i), {63'd0, s_out_valid}, {63'd0, vecs[i].exp_out_valid});
      if (vecs[i].exp_out_valid) check($sformatf("vec%0d_out_pc", i), s_out_pc, vecs[i].exp_out_pc);
    end

    // Backpressure with a full queue stops fetch; releasing it resumes.
    out_ready = 1'b0;
    do_reset();
    repeat (10) tick();
    check("bp_req_valid", {63'd0, s_req_valid}, 64'd0);
    check("bp_out_valid", {63'd0, s_out_valid}, 64'd1);
    check("bp_out_pc", s_out_pc, 64'h8000_0000);
    check("bp_out_inst", {32'd0, s_out_inst}, {32'd0, data_of(64'h8000_0000)});
    out_ready = 1'b1;
    tick();
    tick();
    check("bp_resume_valid", {63'd0, s_req_valid}, 64'd1);
    check("bp_resume_addr", s_req_addr, 64'h8000_0008);
    repeat (8) tick();

    // Redirect while a response is outstanding: the late response is dropped.
    lat = 3;
    do_reset();
    tick();
    check("rd_pending", {63'd0, mem_pend}, 64'd1);
    redirect_to(64'h8000_1000);
    tick();
    check("rd_out_valid", {63'd0, s_out_valid}, 64'd0);
    check("rd_no_req", {63'd0, s_req_valid}, 64'd0);
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (s_req_valid) found = 1;
    end
    check("rd_req_seen", {63'd0, found}, 64'd1);
    check("rd_req_addr", s_req_addr, 64'h8000_1000);
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (s_out_valid) found = 1;
    end
    check("rd_out_seen", {63'd0, found}, 64'd1);
    check("rd_out_pc", s_out_pc, 64'h8000_1000);
    repeat (6) tick();

    // Access fault at 0x80000004 halts fetch until a redirect.
    lat      = 1;
    err_addr = 64'h8000_0004;
    do_reset();
    found = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (s_out_valid && s_out_pc == 64'h8000_0004 && !found) begin
        found = 1;
        check("err_flag", {63'd0, s_out_err}, 64'd1);
      end
    end
    check("err_entry_seen", {63'd0, found}, 64'd1);
    check("err_halt_nreq", n_req, 2);
    check("err_halt_valid", {63'd0, s_req_valid}, 64'd0);
    err_addr = '1;
    redirect_to(64'h8000_2000);
    tick();
    check("err_restart_valid", {63'd0, s_req_valid}, 64'd1);
    check("err_restart_addr", s_req_addr, 64'h8000_2000);
    repeat (6) tick();

    // Misaligned redirect target; an unaccepted request is held stable first.
    imem_req_ready = 1'b0;
    do_reset();
    tick();
    tick();
    redirect_to(64'h8000_0002);
    imem_req_ready = 1'b1;
    tick();
`ifdef YSYX_IFU_MISALIGN_TRAP_EN
    check("mis_no_req", {63'd0, s_req_valid}, 64'd0);
    sb.push_back('{64'h8000_0002, 32'h0, 1'b1});
    tick();
    check("mis_out_valid", {63'd0, s_out_valid}, 64'd1);
    check("mis_out_pc", s_out_pc, 64'h8000_0002);
    check("mis_out_err", {63'd0, s_out_err}, 64'd1);
`else
    check("mis_req_valid", {63'd0, s_req_valid}, 64'd1);
    check("mis_req_addr", s_req_addr, 64'h8000_0002);
    tick();
`endif
    repeat (5) tick();

    // PC increment wraps at the top of the address space.
    imem_req_ready = 1'b0;
    do_reset();
    redirect_to(64'hFFFF_FFFF_FFFF_FFFC);
    imem_req_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (n_req == 2) found = 1;
    end
    check("wrap_seen", {63'd0, found}, 64'd1);
    check("wrap_addr", last_acc_addr, 64'h0);
    repeat (4) tick();

    // Reset while waiting for a response; a stale pulse during reset is ignored.
    lat = 3;
    do_reset();
    tick();
    rst             = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    tick();
    rst = 1'b0;
    tick();
    check("rstw_out_valid", {63'd0, s_out_valid}, 64'd0);
    check("rstw_req_valid", {63'd0, s_req_valid}, 64'd1);
    check("rstw_req_addr", s_req_addr, 64'h8000_0000);
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
